// File: rtl/g_interp_ha_pipe.sv
// Bayer green-channel interpolator: bilinear or Hamilton-Adams, 3-stage pipeline
// with one global advance, output clamp, and a saturating clamp-event counter.
module g_interp_ha_pipe #(
  parameter int DW    = 10,
  parameter int SAT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [25*DW-1:0] in_win,
  input  logic             in_is_g,
  input  logic             in_mode,
  input  logic [1:0]       in_user,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DW-1:0]    out_g,
  output logic [1:0]       out_user,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SAT_W-1:0] sat_cnt
);
  localparam int LW     = DW + 3;
  localparam int RW     = DW + 4;
  localparam int STAGES = 3;

  typedef struct packed {
    logic [LW-1:0] lap_h;
    logic [LW-1:0] lap_v;
    logic [DW+1:0] dh;
    logic [DW+1:0] dv;
    logic [DW:0]   sum_h;
    logic [DW:0]   sum_v;
    logic [DW-1:0] c;
    logic          is_g;
    logic          mode;
    logic [1:0]    user;
  } s1_t;

  typedef struct packed {
    logic [RW-1:0] raw;
    logic          is_g;
    logic [1:0]    user;
  } s2_t;

  function automatic logic [DW-1:0] px(input logic [25*DW-1:0] w, input int idx);
    return w[idx*DW +: DW];
  endfunction

  function automatic logic [LW-1:0] ext(input logic [DW-1:0] p);
    return {3'b000, p};
  endfunction

  function automatic logic [LW-1:0] absv(input logic [LW-1:0] x);
    return x[LW-1] ? (~x + 1'b1) : x;
  endfunction

  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  logic [DW-1:0]   out_g_q, out_g_d;
  logic [1:0]      out_user_q, out_user_d;
  logic            clamp_q, clamp_d;
  logic [SAT_W-1:0] sat_cnt_q, sat_cnt_d;
  logic            adv, xfer;

  assign adv       = !vld_pipe_q[STAGES] || out_ready;
  assign xfer      = vld_pipe_q[STAGES] && out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe_q[STAGES];
  assign out_g     = out_g_q;
  assign out_user  = out_user_q;
  assign sat_cnt   = sat_cnt_q;

  // S1: Laplacians and gradients; LW-bit modular arithmetic is exact two's complement
  logic [DW-1:0] c, gw, ge, gn, gs, cww, cee, cnn, css;
  logic [LW-1:0] lap_h, lap_v, dh_full, dv_full;
  always_comb begin
    c   = px(in_win, 12);
    gw  = px(in_win, 11);
    ge  = px(in_win, 13);
    gn  = px(in_win, 7);
    gs  = px(in_win, 17);
    cww = px(in_win, 10);
    cee = px(in_win, 14);
    cnn = px(in_win, 2);
    css = px(in_win, 22);
    lap_h   = (ext(c) << 1) - ext(cww) - ext(cee);
    lap_v   = (ext(c) << 1) - ext(cnn) - ext(css);
    dh_full = absv(ext(gw) - ext(ge)) + absv(lap_h);
    dv_full = absv(ext(gn) - ext(gs)) + absv(lap_v);
    s1_d       = '0;
    s1_d.lap_h = lap_h;
    s1_d.lap_v = lap_v;
    s1_d.dh    = dh_full[DW+1:0];
    s1_d.dv    = dv_full[DW+1:0];
    s1_d.sum_h = {1'b0, gw} + {1'b0, ge};
    s1_d.sum_v = {1'b0, gn} + {1'b0, gs};
    s1_d.c     = c;
    s1_d.is_g  = in_is_g;
    s1_d.mode  = in_mode;
    s1_d.user  = in_user;
  end

  // S2: direction select and sum, signed RW-bit result before clamp
  logic signed [RW-1:0] lh, lv, lsum, avg_h, avg_v, avg_4, c_s, raw;
  logic [DW+1:0]        quad;
  always_comb begin
    lh    = $signed({s1_q.lap_h[LW-1], s1_q.lap_h});
    lv    = $signed({s1_q.lap_v[LW-1], s1_q.lap_v});
    lsum  = lh + lv;
    quad  = {1'b0, s1_q.sum_h} + {1'b0, s1_q.sum_v};
    avg_h = $signed({4'b0000, s1_q.sum_h[DW:1]});
    avg_v = $signed({4'b0000, s1_q.sum_v[DW:1]});
    avg_4 = $signed({4'b0000, quad[DW+1:2]});
    c_s   = $signed({4'b0000, s1_q.c});
    if (s1_q.is_g)             raw = c_s;
    else if (!s1_q.mode)       raw = avg_4;
    else if (s1_q.dh < s1_q.dv) raw = avg_h + (lh >>> 2);
    else if (s1_q.dh > s1_q.dv) raw = avg_v + (lv >>> 2);
    else                       raw = avg_4 + (lsum >>> 3);
    s2_d      = '0;
    s2_d.raw  = raw;
    s2_d.is_g = s1_q.is_g;
    s2_d.user = s1_q.user;
  end

  // S3: clamp; green-centre passthrough never counts as a clamp event
  logic neg, ovf;
  always_comb begin
    neg        = s2_q.raw[RW-1];
    ovf        = !neg && (|s2_q.raw[RW-2:DW]);
    out_g_d    = s2_q.raw[DW-1:0];
    out_user_d = s2_q.user;
    clamp_d    = 1'b0;
    if (!s2_q.is_g) begin
      if (neg) begin
        out_g_d = '0;
        clamp_d = 1'b1;
      end else if (ovf) begin
        out_g_d = '1;
        clamp_d = 1'b1;
      end
    end
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
    sat_cnt_d  = sat_cnt_q;
    if (xfer && clamp_q && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      out_g_q    <= '0;
      out_user_q <= '0;
      clamp_q    <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      if (adv) begin
        vld_pipe_q <= vld_pipe_d;
        s1_q       <= s1_d;
        s2_q       <= s2_d;
        out_g_q    <= out_g_d;
        out_user_q <= out_user_d;
        clamp_q    <= clamp_d;
      end
      sat_cnt_q <= sat_cnt_d;
    end
  end
endmodule

// File: doc/g_interp_ha_pipe.md
G_INTERP_HA_PIPE -- requirements
Module: g_interp_ha_pipe

Interface
REQ-001 Parameter DW, default 10, pixel bit width; legal range 8..16.
REQ-002 Parameter SAT_W, default 16, width of the clamp-event counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_win  input  25*DW  5x5 Bayer window; pixel (r,c) at bits [(r*5+c)*DW +: DW], r = row 0..4, c = column 0..4, centre (2,2).
REQ-006 in_is_g  input  1  1 = centre sample is green.
REQ-007 in_mode  input  1  0 = bilinear, 1 = Hamilton-Adams.
REQ-008 in_user  input  2  sideband bits (SOF, EOL), carried unchanged.
REQ-009 in_valid  input  1  input beat valid.
REQ-010 in_ready  output  1  pipeline can accept a beat.
REQ-011 out_g  output  DW  interpolated green.
REQ-012 out_user  output  2  sideband aligned with out_g.
REQ-013 out_valid  output  1  output beat valid.
REQ-014 out_ready  input  1  downstream accepts beat.
REQ-015 sat_cnt  output  SAT_W  count of clamped outputs since reset.

Function
REQ-016 Names: C = (2,2); GW = (2,1); GE = (2,3); GN = (1,2); GS = (3,2); CWW = (2,0); CEE = (2,4); CNN = (0,2); CSS = (4,2).
REQ-017 Pipeline is 3 register stages: S1 gradients/Laplacians; S2 direction select and sum; S3 clamp and output register.
REQ-018 Latency from in_valid&&in_ready to out_valid is exactly 3 cycles with no stall.
REQ-019 Global advance adv = !out_valid || out_ready; in_ready = adv; all stages and valid bits shift only when adv = 1.
REQ-020 While out_valid=1 and out_ready=0, out_g, out_user and out_valid hold stable.
REQ-021 A beat accepted with in_valid=0 inserts a bubble (valid bit 0); bubbles are not compressed.
REQ-022 lapH = 2C - CWW - CEE; lapV = 2C - CNN - CSS; signed, DW+3 bits.
REQ-023 dH = |GW-GE| + |lapH|; dV = |GN-GS| + |lapV|; unsigned, DW+2 bits.
REQ-024 Hamilton mode, dH<dV: result = floor((GW+GE)/2) + (lapH >>> 2).
REQ-025 Hamilton mode, dH>dV: result = floor((GN+GS)/2) + (lapV >>> 2).
REQ-026 Hamilton mode, dH=dV: result = floor((GW+GE+GN+GS)/4) + ((lapH+lapV) >>> 3).
REQ-027 >>> is an arithmetic shift, i.e. floor toward minus infinity; all sums are exact, with no intermediate truncation.
REQ-028 Bilinear mode: result = floor((GW+GE+GN+GS)/4).
REQ-029 in_is_g=1: result = C, in either mode, with no clamp event.
REQ-030 Clamp: result<0 gives 0; result>2^DW-1 gives 2^DW-1; otherwise the result passes through.
REQ-031 in_mode, in_is_g and in_user are sampled with the beat and travel with it; a mode change between beats takes effect per beat.
REQ-032 sat_cnt increments by 1 when a clamped beat is transferred (out_valid && out_ready); it saturates at 2^SAT_W-1.

Reset
REQ-033 On rst=1 at a clock edge: all stage valid bits clear, out_valid=0, out_g=0, out_user=0, sat_cnt=0.
REQ-034 in_ready=1 in the cycle after reset; beats in flight at reset are discarded and never appear at the output.
REQ-035 rst has priority over adv and over in_valid in the same cycle.

Verification (DW=10)
REQ-036 All 25 pixels = 512, in_is_g=0, Hamilton mode, out_ready=1: out_g=512 exactly 3 cycles after acceptance.
REQ-037 C=CWW=CEE=CNN=CSS=200, GW=GE=100, GN=800, GS=0, Hamilton mode: dH=0, dV=800; out_g=100.
REQ-038 C=GW=GE=GS=1023, CWW=CEE=CNN=CSS=GN=0, Hamilton mode: dH=2046, dV=3069; raw result 1534 clamps to out_g=1023; sat_cnt goes 0 to 1.
REQ-039 C=GW=GE=0, CWW=CEE=CNN=CSS=GN=GS=1023, Hamilton mode: dH=dV=2046; raw result 511-512 = -1 clamps to out_g=0; sat_cnt increments.
REQ-040 Continuous in_valid, out_ready=0 for 4 cycles with the pipe full: in_ready=0, out_g held; after release, all beats emerge in order with none lost or duplicated.
REQ-041 rst pulsed for 1 cycle with 2 beats in flight: out_valid=0 next cycle, sat_cnt=0; the first new beat emerges 3 cycles after its acceptance.
